// File: rtl/c499_enc_pkg.sv
// rtl/c499_enc_pkg.sv - shared constants and codeword type for the c499 SEC encoder
package c499_enc_pkg;

   localparam int CW_W = 40;

   localparam logic [31:0] MASK_C0 = 32'h00FF1111;
   localparam logic [31:0] MASK_C1 = 32'hFF002222;
   localparam logic [31:0] MASK_C2 = 32'h0F0F4444;
   localparam logic [31:0] MASK_C3 = 32'hF0F08888;
   localparam logic [31:0] MASK_C4 = 32'h111100FF;
   localparam logic [31:0] MASK_C5 = 32'h2222FF00;
   localparam logic [31:0] MASK_C6 = 32'h44440F0F;
   localparam logic [31:0] MASK_C7 = 32'h8888F0F0;

   // Indexed by check bit so the slice can walk all eight masks in a loop
   localparam logic [7:0][31:0] MASK_ALL = {MASK_C7, MASK_C6, MASK_C5, MASK_C4,
                                            MASK_C3, MASK_C2, MASK_C1, MASK_C0};

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  chk;
   } cw_t;

endpackage

// File: rtl/c499_enc_slice.sv
// rtl/c499_enc_slice.sv - check-bit contribution of one data byte at word slot k
module c499_enc_slice
   import c499_enc_pkg::*;
(
   input  logic [1:0] k,
   input  logic [7:0] din,
   output logic [7:0] contrib
);

   always_comb begin
      contrib = '0;
      for (int i = 0; i < 8; i++) begin
         contrib[i] = ^(din & MASK_ALL[i][{k, 3'b000} +: 8]);
      end
   end

endmodule

// File: rtl/c499_sec_encoder.sv
// rtl/c499_sec_encoder.sv - byte-serial c499 SEC check-bit generator with fault injector
module c499_sec_encoder
   import c499_enc_pkg::*;
#(
   parameter bit INJ_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_byte,
   input  logic        sync,
   input  logic        inj_en,
   input  logic [5:0]  inj_pos,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_chk,
   output logic        out_chk_en
);

   logic [1:0]      cnt;
   logic [1:0]      cur_cnt;
   logic [7:0]      acc;
   logic [7:0]      cur_acc;
   logic [7:0]      contrib;
   logic [23:0]     accum;
   cw_t             out_q;
   cw_t             cw_next;
   logic            out_valid_q;
   logic [CW_W-1:0] flip;
   logic            accept;
   logic            complete;

   // Only the completing byte can be blocked: earlier bytes never touch the output register
   assign in_ready = rst_n && !(cnt == 2'd3 && out_valid_q && !out_ready);

   // sync takes effect before the same-cycle byte, which becomes byte 0
   assign cur_cnt  = sync ? 2'd0 : cnt;
   assign cur_acc  = sync ? 8'd0 : acc;
   assign accept   = in_valid && in_ready;
   assign complete = accept && (cur_cnt == 2'd3);

   c499_enc_slice u_slice (
      .k       (cur_cnt),
      .din     (in_byte),
      .contrib (contrib)
   );

   generate
      if (INJ_EN) begin : g_inj
         // Shifting past bit 39 yields zero, so positions >= 40 flip nothing
         assign flip = (inj_en && inj_pos < 6'd40) ? (40'd1 << inj_pos) : '0;
      end else begin : g_no_inj
         assign flip = '0;
      end
   endgenerate

   // Check bits come from the clean data; the flip is applied afterwards
   always_comb begin
      cw_next.data = {in_byte, accum} ^ flip[31:0];
      cw_next.chk  = (cur_acc ^ contrib) ^ flip[39:32];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= 2'd0;
         acc         <= 8'd0;
         accum       <= 24'd0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         if (sync) begin
            cnt <= 2'd0;
            acc <= 8'd0;
         end
         if (complete) begin
            out_q       <= cw_next;
            out_valid_q <= 1'b1;
            cnt         <= 2'd0;
            acc         <= 8'd0;
         end else begin
            if (accept) begin
               case (cur_cnt)
                  2'd0:    accum[7:0]   <= in_byte;
                  2'd1:    accum[15:8]  <= in_byte;
                  default: accum[23:16] <= in_byte;
               endcase
               acc <= cur_acc ^ contrib;
               cnt <= cur_cnt + 2'd1;
            end
            if (out_valid_q && out_ready) begin
               out_valid_q <= 1'b0;
            end
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_chk_en = out_valid_q;
   assign out_data   = out_q.data;
   assign out_chk    = out_q.chk;

endmodule
